// File: rtl/poly_tone_pwm_if.sv
// ---------------------------------------------------------------------------
// poly_tone_pwm_if
//   Control and audio-output bundle of the polyphonic tone generator.
//   master : the controller side (drives writes, enables and volume buttons)
//   slave  : the tone generator itself
//
//   wr_en           load wr_half_period into channel wr_ch
//   wr_ch           channel index (CH_W bits)
//   wr_half_period  half-period in clk cycles, 0 silences the channel
//   ch_enable       per-channel enable level
//   vol_up/vol_down debounced volume buttons (edge triggered inside)
//   audio           registered 1-bit PWM audio
//   shutdown        amplifier enable, 1 = amp on
//   active_mask     registered per-channel activity
//   volume          current volume
// ---------------------------------------------------------------------------
interface poly_tone_pwm_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 20,
    parameter int VOL_W    = 3
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [DIV_W-1:0]    wr_half_period;
    logic [CHANNELS-1:0] ch_enable;
    logic                vol_up;
    logic                vol_down;
    logic                audio;
    logic                shutdown;
    logic [CHANNELS-1:0] active_mask;
    logic [VOL_W-1:0]    volume;

    modport master (
        output wr_en, wr_ch, wr_half_period, ch_enable, vol_up, vol_down,
        input  audio, shutdown, active_mask, volume
    );

    modport slave (
        input  wr_en, wr_ch, wr_half_period, ch_enable, vol_up, vol_down,
        output audio, shutdown, active_mask, volume
    );
endinterface

// File: rtl/poly_tone_pwm.sv
// ---------------------------------------------------------------------------
// poly_tone_pwm
//   Polyphonic square-wave tone generator with PWM mixer, up/down volume and
//   idle-driven amplifier shutdown.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    poly_tone_pwm_if.slave (write port, enables, volume buttons,
//          audio, shutdown, active_mask, volume)
//
//   Each channel toggles its tone bit every hp clk cycles while enabled with
//   a non-zero half-period. Enabled tone bits are summed, scaled by the
//   volume and a fixed gain K chosen so the full-scale product fits the PWM
//   range, and the resulting duty is latched once per PWM frame.
//   The interface instance must be built with the same CHANNELS, DIV_W and
//   VOL_W as this module.
// ---------------------------------------------------------------------------
module poly_tone_pwm #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 20,
    parameter int PWM_W    = 8,
    parameter int VOL_W    = 3,
    parameter int VOL_INIT = 4,
    parameter int IDLE_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    poly_tone_pwm_if.slave     bus
);
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W   = $clog2(CHANNELS + 1);
    localparam int IDLE_W  = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    localparam int PWM_MAX = (1 << PWM_W) - 1;
    localparam int VOL_MAX = (1 << VOL_W) - 1;
    // Largest gain for which CHANNELS*VOL_MAX*K still fits in PWM_W bits,
    // so the duty product below can never overflow.
    localparam int K       = PWM_MAX / (CHANNELS * VOL_MAX);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [VOL_W-1:0]  VOL_TOP   = '1;

    // Per-channel state
    logic [DIV_W-1:0]    hp  [CHANNELS];
    logic [DIV_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] tone;

    // Per-channel decode
    logic [CHANNELS-1:0] ch_act;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] cnt_wrap;

    // Mixer / PWM
    logic [SUM_W-1:0]    sum;
    logic [PWM_W-1:0]    duty_next;
    logic [PWM_W-1:0]    duty_reg;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                audio_q;

    // Volume
    logic                prev_up;
    logic                prev_down;
    logic                up_edge;
    logic                down_edge;
    logic [VOL_W-1:0]    vol_q;

    // Shutdown
    logic                any_active;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                shutdown_q;
    logic [CHANNELS-1:0] active_q;

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop so no path can leave it unassigned and infer a latch.
        ch_act   = '0;
        wr_hit   = '0;
        cnt_wrap = '0;
        sum      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_act[c]   = bus.ch_enable[c] && (hp[c] != '0);
            // Indices at or above CHANNELS never match, so such writes drop.
            wr_hit[c]   = bus.wr_en && (bus.wr_ch == CH_W'(c));
            cnt_wrap[c] = (cnt[c] == hp[c] - DIV_W'(1));
            if (tone[c] && bus.ch_enable[c]) begin
                sum = sum + SUM_W'(1);
            end
        end
        duty_next  = PWM_W'(sum) * PWM_W'(vol_q) * PWM_W'(K);
        up_edge    = bus.vol_up   & ~prev_up;
        down_edge  = bus.vol_down & ~prev_down;
        any_active = |ch_act;
    end

    // -----------------------------------------------------------------------
    // Tone channels
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: hp/cnt are small register arrays, not a RAM, so they are
            // cleared explicitly; a silent restart depends on hp being 0.
            for (int c = 0; c < CHANNELS; c++) begin
                hp[c]  <= '0;
                cnt[c] <= '0;
            end
            tone <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_hit[c]) begin
                    // Phase restart: first rise lands hp edges after the write.
                    hp[c]   <= bus.wr_half_period;
                    cnt[c]  <= '0;
                    tone[c] <= 1'b0;
                end else if (ch_act[c]) begin
                    if (cnt_wrap[c]) begin
                        cnt[c]  <= '0;
                        tone[c] <= ~tone[c];
                    end else begin
                        cnt[c]  <= cnt[c] + DIV_W'(1);
                    end
                end else begin
                    cnt[c]  <= '0;
                    tone[c] <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // PWM: duty only changes at the frame wrap, so a frame is never cut short
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            duty_reg <= '0;
            audio_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here mean duty_reg and audio_q
            // both see the pre-edge pwm_cnt, independent of statement order.
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (pwm_cnt == '1) begin
                duty_reg <= duty_next;
            end
            audio_q <= (pwm_cnt < duty_reg);
        end
    end

    // -----------------------------------------------------------------------
    // Volume: one step per rising edge, simultaneous edges cancel
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
            vol_q     <= VOL_W'(VOL_INIT);
        end else begin
            prev_up   <= bus.vol_up;
            prev_down <= bus.vol_down;
            if (up_edge && !down_edge && (vol_q != VOL_TOP)) begin
                vol_q <= vol_q + VOL_W'(1);
            end else if (down_edge && !up_edge && (vol_q != '0)) begin
                vol_q <= vol_q - VOL_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Activity mask and amplifier shutdown
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= '0;
            idle_cnt   <= '0;
            shutdown_q <= 1'b0;
        end else begin
            active_q <= ch_act;
            if (any_active) begin
                idle_cnt   <= '0;
                shutdown_q <= 1'b1;
            end else if (idle_cnt == IDLE_LAST) begin
                // Counter parks here; the amp goes off IDLE_CYC cycles after
                // the last active cycle.
                shutdown_q <= 1'b0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    assign bus.audio       = audio_q;
    assign bus.shutdown    = shutdown_q;
    assign bus.active_mask = active_q;
    assign bus.volume      = vol_q;

endmodule

// File: tb/tb_poly_tone_pwm.sv
// ---------------------------------------------------------------------------
// tb_poly_tone_pwm
//   Directed bench for poly_tone_pwm: reset, single tone and PWM frames,
//   volume stepping, four-voice mix, ignored writes on a 3-channel build,
//   amplifier shutdown timing, fast tone / rewrite, and mid-run reset.
// ---------------------------------------------------------------------------
module tb_poly_tone_pwm;
    localparam int K4 = 9;   // floor(255 / (4*7))

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ecount;            // clock edges since reset release

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    poly_tone_pwm_if #(.CHANNELS(4)) bus  ();
    poly_tone_pwm_if #(.CHANNELS(3)) bus3 ();

    poly_tone_pwm #(.CHANNELS(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    poly_tone_pwm #(.CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_hp(input int ch, input int hp, output int w);
        bus.wr_en          = 1'b1;
        bus.wr_ch          = 2'(ch);
        bus.wr_half_period = 20'(hp);
        tick();
        bus.wr_en = 1'b0;
        w = ecount;
    endtask

    // Audio high-count per frame against duty derived from the tone model:
    // tone after edge e is ((e-w)/hp) odd; duty is latched at the wrap edge E
    // from the tones present after edge E-1.
    task automatic check_frames(input int hp, input int w, input int nch,
                                input int vol, input int nframes);
        int guard = 0;
        while ((ecount % 256) != 0 && guard < 300) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 300) begin
            n_errors++;
            $display("FAIL frame_sync: no wrap within %0d cycles", guard);
        end
        for (int f = 0; f < nframes; f++) begin
            int e_wrap = ecount;
            int te     = ((e_wrap - 1 - w) / hp) % 2;
            int expd   = (te != 0) ? nch * vol * K4 : 0;
            int highs  = 0;
            for (int j = 0; j < 256; j++) begin
                tick();
                if (bus.audio === 1'b1) highs++;
            end
            n_checks++;
            if (highs !== expd) begin
                n_errors++;
                $display("FAIL frame_duty[%0d]: got %0d high cycles, expected %0d", f, highs, expd);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.audio !== 1'b0) begin n_errors++; $display("FAIL rst_audio: got %b expected 0", bus.audio); end
        n_checks++; if (bus.shutdown !== 1'b0) begin n_errors++; $display("FAIL rst_shutdown: got %b expected 0", bus.shutdown); end
        n_checks++; if (bus.active_mask !== 4'h0) begin n_errors++; $display("FAIL rst_mask: got %h expected 0", bus.active_mask); end
        n_checks++; if (bus.volume !== 3'd4) begin n_errors++; $display("FAIL rst_volume: got %0d expected 4", bus.volume); end
        n_checks++; if (dut.tone !== 4'h0) begin n_errors++; $display("FAIL rst_tone: got %h expected 0", dut.tone); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_tone();
        int w;
        logic exp_t;
        bus.ch_enable = 4'b0001;
        write_hp(0, 5, w);
        n_checks++; if (bus.active_mask !== 4'h0) begin n_errors++; $display("FAIL tone_mask_write_edge: got %h expected 0", bus.active_mask); end
        n_checks++; if (dut.tone[0] !== 1'b0) begin n_errors++; $display("FAIL tone_write_edge: got %b expected 0", dut.tone[0]); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_t = (((ecount - w) / 5) % 2) != 0;
            n_checks++;
            if (dut.tone[0] !== exp_t) begin
                n_errors++;
                $display("FAIL tone0_k%0d: got %b expected %b", k, dut.tone[0], exp_t);
            end
        end
        n_checks++; if (bus.active_mask !== 4'b0001) begin n_errors++; $display("FAIL tone_mask: got %h expected 1", bus.active_mask); end
        n_checks++; if (bus.shutdown !== 1'b1) begin n_errors++; $display("FAIL tone_shutdown: got %b expected 1", bus.shutdown); end
        check_frames(5, w, 1, 4, 4);
    endtask

    task automatic test_volume();
        int exp_up[3] = '{6, 7, 7};
        int exp_v;
        bus.vol_up = 1'b1;
        tick();
        n_checks++; if (bus.volume !== 3'd5) begin n_errors++; $display("FAIL vol_hold_first: got %0d expected 5", bus.volume); end
        repeat (9) tick();
        n_checks++; if (bus.volume !== 3'd5) begin n_errors++; $display("FAIL vol_hold_end: got %0d expected 5", bus.volume); end
        bus.vol_up = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.vol_up = 1'b1; tick();
            bus.vol_up = 1'b0; tick();
            n_checks++;
            if (bus.volume !== 3'(exp_up[i])) begin
                n_errors++;
                $display("FAIL vol_up_%0d: got %0d expected %0d", i, bus.volume, exp_up[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            bus.vol_down = 1'b1; tick();
            bus.vol_down = 1'b0; tick();
            exp_v = (i < 7) ? 6 - i : 0;
            n_checks++;
            if (bus.volume !== 3'(exp_v)) begin
                n_errors++;
                $display("FAIL vol_down_%0d: got %0d expected %0d", i, bus.volume, exp_v);
            end
        end
        bus.vol_up = 1'b1; tick();
        bus.vol_up = 1'b0; tick();
        n_checks++; if (bus.volume !== 3'd1) begin n_errors++; $display("FAIL vol_up_from0: got %0d expected 1", bus.volume); end
        bus.vol_up = 1'b1; bus.vol_down = 1'b1; tick();
        n_checks++; if (bus.volume !== 3'd1) begin n_errors++; $display("FAIL vol_both: got %0d expected 1", bus.volume); end
        bus.vol_up = 1'b0; bus.vol_down = 1'b0; tick();
        n_checks++; if (bus.volume !== 3'd1) begin n_errors++; $display("FAIL vol_both_release: got %0d expected 1", bus.volume); end
    endtask

    task automatic test_all_channels();
        int w;
        bus.ch_enable = 4'b0000;
        for (int c = 0; c < 4; c++) write_hp(c, 100, w);
        for (int i = 0; i < 6; i++) begin
            bus.vol_up = 1'b1; tick();
            bus.vol_up = 1'b0; tick();
        end
        n_checks++; if (bus.volume !== 3'd7) begin n_errors++; $display("FAIL all_volume: got %0d expected 7", bus.volume); end
        bus.ch_enable = 4'b1111;
        tick();
        w = ecount - 1;
        repeat (98) tick();
        n_checks++; if (dut.tone !== 4'h0) begin n_errors++; $display("FAIL all_tone_pre: got %h expected 0", dut.tone); end
        tick();
        n_checks++; if (dut.tone !== 4'hF) begin n_errors++; $display("FAIL all_tone_rise: got %h expected f", dut.tone); end
        n_checks++; if (bus.active_mask !== 4'hF) begin n_errors++; $display("FAIL all_mask: got %h expected f", bus.active_mask); end
        check_frames(100, w, 4, 7, 3);
    endtask

    task automatic test_ignored_write();
        bus3.ch_enable      = 3'b111;
        bus3.wr_en          = 1'b1;
        bus3.wr_ch          = 2'd3;
        bus3.wr_half_period = 20'd7;
        tick();
        bus3.wr_en = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus3.active_mask !== 3'b000) begin n_errors++; $display("FAIL ign_mask: got %b expected 000", bus3.active_mask); end
        n_checks++; if (bus3.shutdown !== 1'b0) begin n_errors++; $display("FAIL ign_shutdown: got %b expected 0", bus3.shutdown); end
        n_checks++;
        if ((dut3.hp[0] | dut3.hp[1] | dut3.hp[2]) !== 20'd0) begin
            n_errors++;
            $display("FAIL ign_hp: got %0d/%0d/%0d expected 0/0/0", dut3.hp[0], dut3.hp[1], dut3.hp[2]);
        end
        bus3.wr_en = 1'b1;
        bus3.wr_ch = 2'd2;
        tick();
        bus3.wr_en = 1'b0;
        tick();
        n_checks++; if (bus3.active_mask !== 3'b100) begin n_errors++; $display("FAIL ign_ctrl_mask: got %b expected 100", bus3.active_mask); end
        n_checks++; if (bus3.shutdown !== 1'b1) begin n_errors++; $display("FAIL ign_ctrl_shutdown: got %b expected 1", bus3.shutdown); end
    endtask

    task automatic test_shutdown();
        n_checks++; if (bus.shutdown !== 1'b1) begin n_errors++; $display("FAIL sd_pre: got %b expected 1", bus.shutdown); end
        bus.ch_enable = 4'b0000;
        for (int n = 1; n <= 1024; n++) begin
            tick();
            if (n == 1) begin
                n_checks++; if (bus.active_mask !== 4'h0) begin n_errors++; $display("FAIL sd_mask: got %h expected 0", bus.active_mask); end
            end
            if (n == 1023) begin
                n_checks++; if (bus.shutdown !== 1'b1) begin n_errors++; $display("FAIL sd_hold_1023: got %b expected 1", bus.shutdown); end
            end
            if (n == 1024) begin
                n_checks++; if (bus.shutdown !== 1'b0) begin n_errors++; $display("FAIL sd_fall_1024: got %b expected 0", bus.shutdown); end
            end
        end
        bus.ch_enable = 4'b0001;
        tick();
        n_checks++; if (bus.shutdown !== 1'b1) begin n_errors++; $display("FAIL sd_wake: got %b expected 1", bus.shutdown); end
    endtask

    task automatic test_fast_tone();
        int w;
        int exp_r[3] = '{0, 0, 1};
        bus.ch_enable = 4'b0010;
        write_hp(1, 1, w);
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (dut.tone[1] !== 1'((ecount - w) % 2)) begin
                n_errors++;
                $display("FAIL fast_k%0d: got %b expected %0d", k, dut.tone[1], (ecount - w) % 2);
            end
        end
        write_hp(1, 3, w);
        n_checks++; if (dut.tone[1] !== 1'b0) begin n_errors++; $display("FAIL rewrite_tone: got %b expected 0", dut.tone[1]); end
        n_checks++; if (dut.cnt[1] !== 20'd0) begin n_errors++; $display("FAIL rewrite_cnt: got %0d expected 0", dut.cnt[1]); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (dut.tone[1] !== 1'(exp_r[k])) begin
                n_errors++;
                $display("FAIL rewrite_k%0d: got %b expected %0d", k + 1, dut.tone[1], exp_r[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.audio !== 1'b0) begin n_errors++; $display("FAIL mid_audio: got %b expected 0", bus.audio); end
        n_checks++; if (bus.shutdown !== 1'b0) begin n_errors++; $display("FAIL mid_shutdown: got %b expected 0", bus.shutdown); end
        n_checks++; if (bus.active_mask !== 4'h0) begin n_errors++; $display("FAIL mid_mask: got %h expected 0", bus.active_mask); end
        n_checks++; if (bus.volume !== 3'd4) begin n_errors++; $display("FAIL mid_volume: got %0d expected 4", bus.volume); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) tick();
        n_checks++; if (dut.tone !== 4'h0) begin n_errors++; $display("FAIL mid_no_restart: got %h expected 0", dut.tone); end
        n_checks++; if (bus.active_mask !== 4'h0) begin n_errors++; $display("FAIL mid_mask_after: got %h expected 0", bus.active_mask); end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_half_period = '0;
        bus.ch_enable = '0; bus.vol_up = 1'b0; bus.vol_down = 1'b0;
        bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_half_period = '0;
        bus3.ch_enable = '0; bus3.vol_up = 1'b0; bus3.vol_down = 1'b0;
        test_reset();
        test_single_tone();
        test_volume();
        test_all_channels();
        test_ignored_write();
        test_shutdown();
        test_fast_tone();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
